// File: rtl/video_sprite_dma.sv
// video_sprite_dma
//   Copies 8-bit sprite pixels from system memory into the sprite unit's
//   pixel window. Each 32-bit memory word carries four pixels (little-endian
//   lanes); each pixel becomes one sprite data write. Transfers may be held
//   off until the next rising edge of vertical blank to avoid tearing.
//
// Ports
//   i_clock, i_reset           clock, synchronous active-high reset
//   i_request/i_rw/i_address/  CPU register access (SRC 0x0, DST 0x4,
//   i_wdata/o_rdata/o_ready    COUNT 0x8, CTRL/STATUS 0xC); ack next cycle
//   o_bus_*/i_bus_*            32-bit memory read port, held until ready
//   o_sprite_*/i_sprite_ready  sprite write bus, one-cycle strobe then wait
//   i_video_vblank             vertical blank level
//
// state      | meaning
// S_IDLE     | not busy, waiting for CTRL.start
// S_WAIT_VB  | armed, waiting for a rising edge of vblank
// S_READ     | memory read outstanding at src_ptr
// S_WRITE    | sprite strobe high for the current lane
// S_WR_WAIT  | strobe low, waiting for sprite acknowledge
// S_DONE     | one-cycle completion, done flag set
module video_sprite_dma #(
    parameter logic [31:0] SPRITE_BASE = 32'h0000_0000,
    parameter int          COUNT_WIDTH = 13
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_request,
    input  logic        i_rw,
    input  logic [3:0]  i_address,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_ready,
    output logic        o_bus_request,
    output logic [31:0] o_bus_address,
    input  logic        i_bus_ready,
    input  logic [31:0] i_bus_rdata,
    output logic        o_sprite_request,
    output logic [31:0] o_sprite_address,
    output logic [31:0] o_sprite_wdata,
    input  logic        i_sprite_ready,
    input  logic        i_video_vblank
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_VB, S_READ, S_WRITE, S_WR_WAIT, S_DONE
    } state_t;

    state_t                 state_q;
    logic [31:0]            src_q, src_ptr_q, word_q;
    logic [11:0]            dst_q, dst_ptr_q;
    logic [COUNT_WIDTH-1:0] count_q, rem_q;
    logic [1:0]             lane_q;
    logic                   done_q, abort_q, vb_prev_q;
    logic                   ready_q, bus_req_q, spr_req_q;
    logic [31:0]            rdata_q, bus_addr_q, spr_addr_q, spr_wdata_q;

    logic        busy, reg_wr, ctrl_wr, start_go;
    logic [31:0] rd_mux;

    assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
    assign reg_wr   = i_request && i_rw;
    assign ctrl_wr  = reg_wr && (i_address == 4'hC);
    assign start_go = ctrl_wr && i_wdata[0] && !busy;

    always_comb begin
        rd_mux = 32'h0;
        case (i_address)
            4'h0:    rd_mux = src_q;
            4'h4:    rd_mux = {20'h0, dst_q};
            4'h8:    rd_mux = {{(32-COUNT_WIDTH){1'b0}}, count_q};
            4'hC:    rd_mux = {30'h0, done_q, busy};
            default: rd_mux = 32'h0;
        endcase
    end

    function automatic logic [31:0] pix_addr(input logic [11:0] idx);
        return SPRITE_BASE + 32'h0000_4000 + {18'h0, idx, 2'b00};
    endfunction

    function automatic logic [31:0] pix_data(input logic [31:0] w, input logic [1:0] lane);
        case (lane)
            2'd0:    return {24'h0, w[7:0]};
            2'd1:    return {24'h0, w[15:8]};
            2'd2:    return {24'h0, w[23:16]};
            default: return {24'h0, w[31:24]};
        endcase
    endfunction

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q     <= S_IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            count_q     <= '0;
            src_ptr_q   <= '0;
            dst_ptr_q   <= '0;
            rem_q       <= '0;
            word_q      <= '0;
            lane_q      <= '0;
            done_q      <= 1'b0;
            abort_q     <= 1'b0;
            vb_prev_q   <= 1'b0;
            ready_q     <= 1'b0;
            rdata_q     <= '0;
            bus_req_q   <= 1'b0;
            bus_addr_q  <= '0;
            spr_req_q   <= 1'b0;
            spr_addr_q  <= '0;
            spr_wdata_q <= '0;
        end else begin
            vb_prev_q <= i_video_vblank;
            ready_q   <= i_request;
            rdata_q   <= (i_request && !i_rw) ? rd_mux : 32'h0;

            if (reg_wr && !busy) begin
                case (i_address)
                    4'h0:    src_q   <= {i_wdata[31:2], 2'b00};
                    4'h4:    dst_q   <= i_wdata[11:0];
                    4'h8:    count_q <= i_wdata[COUNT_WIDTH-1:0];
                    default: ;
                endcase
            end
            // Abort is only remembered here; each state retires it once
            // its own handshake is complete.
            if (ctrl_wr && i_wdata[2] && busy)
                abort_q <= 1'b1;

            case (state_q)
                S_IDLE, S_DONE: begin
                    state_q <= S_IDLE;
                    if (start_go) begin
                        done_q    <= 1'b0;
                        abort_q   <= 1'b0;
                        src_ptr_q <= src_q;
                        dst_ptr_q <= dst_q;
                        rem_q     <= count_q;
                        lane_q    <= 2'd0;
                        if (count_q == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else if (i_wdata[1]) begin
                            state_q <= S_WAIT_VB;
                        end else begin
                            state_q    <= S_READ;
                            bus_req_q  <= 1'b1;
                            bus_addr_q <= src_q;
                        end
                    end
                end
                S_WAIT_VB: begin
                    if (abort_q) begin
                        state_q <= S_IDLE;
                        abort_q <= 1'b0;
                    end else if (i_video_vblank && !vb_prev_q) begin
                        state_q    <= S_READ;
                        bus_req_q  <= 1'b1;
                        bus_addr_q <= src_ptr_q;
                    end
                end
                S_READ: begin
                    if (i_bus_ready) begin
                        bus_req_q <= 1'b0;
                        word_q    <= i_bus_rdata;
                        if (abort_q) begin
                            state_q <= S_IDLE;
                            abort_q <= 1'b0;
                        end else begin
                            state_q     <= S_WRITE;
                            spr_req_q   <= 1'b1;
                            spr_addr_q  <= pix_addr(dst_ptr_q);
                            spr_wdata_q <= {24'h0, i_bus_rdata[7:0]};
                        end
                    end
                end
                S_WRITE: begin
                    spr_req_q <= 1'b0;
                    state_q   <= S_WR_WAIT;
                end
                S_WR_WAIT: begin
                    if (i_sprite_ready) begin
                        dst_ptr_q <= dst_ptr_q + 12'd1;
                        rem_q     <= rem_q - 1'b1;
                        lane_q    <= lane_q + 2'd1;
                        if (abort_q) begin
                            state_q <= S_IDLE;
                            abort_q <= 1'b0;
                        end else if (rem_q == COUNT_WIDTH'(1)) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else if (lane_q == 2'd3) begin
                            state_q    <= S_READ;
                            src_ptr_q  <= src_ptr_q + 32'd4;
                            bus_req_q  <= 1'b1;
                            bus_addr_q <= src_ptr_q + 32'd4;
                        end else begin
                            state_q     <= S_WRITE;
                            spr_req_q   <= 1'b1;
                            spr_addr_q  <= pix_addr(dst_ptr_q + 12'd1);
                            spr_wdata_q <= pix_data(word_q, lane_q + 2'd1);
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_rdata          = rdata_q;
    assign o_ready          = ready_q;
    assign o_bus_request    = bus_req_q;
    assign o_bus_address    = bus_addr_q;
    assign o_sprite_request = spr_req_q;
    assign o_sprite_address = spr_addr_q;
    assign o_sprite_wdata   = spr_wdata_q;

endmodule
